// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage (P) and an auxiliary master (A).
// Build option: define DMEM_ARB_RR_EN for round-robin contention instead of P-priority with starvation limit.
module dmem_port_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_req,
    input  logic        p_we,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    input  logic [1:0]  p_lwhb,
    input  logic [1:0]  p_swhb,
    input  logic        p_lu,
    output logic        p_stall,
    output logic        p_rvalid,
    output logic [31:0] p_rdata,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [1:0]  a_lwhb,
    input  logic [1:0]  a_swhb,
    input  logic        a_lu,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_lwhb,
    output logic [1:0]  m_swhb,
    output logic        m_lu,
    input  logic [31:0] m_rdata
);

    logic contend;
    logic a_wins;
    logic grant_p;
    logic grant_a;
    logic read_issue;

    logic [RD_LAT-1:0] own_v_q, own_v_d;
    logic [RD_LAT-1:0] own_a_q, own_a_d;

`ifdef DMEM_ARB_RR_EN
    typedef enum logic {PORT_P = 1'b0, PORT_A = 1'b1} port_e;
    port_e rr_ptr_q, rr_ptr_d;
`else
    localparam logic [3:0] LIM = 4'(STARVE_LIM);
    logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

    assign contend = p_req & a_valid;

`ifdef DMEM_ARB_RR_EN
    assign a_wins = contend & (rr_ptr_q == PORT_A);
`else
    assign a_wins = contend & (starve_cnt_q == LIM);
`endif

    // Grants are gated by reset so nothing reaches dmem while reset is held low.
    assign grant_p    = reset & p_req & ~a_wins;
    assign grant_a    = reset & a_valid & ~grant_p;
    assign read_issue = (grant_p & ~p_we) | (grant_a & ~a_we);

    assign p_stall = p_req & ~grant_p & reset;
    assign a_ready = a_valid & grant_a;
    assign m_en    = grant_p | grant_a;

    always_comb begin
        m_we    = 1'b0;
        m_addr  = p_addr;
        m_wdata = p_wdata;
        m_lwhb  = p_lwhb;
        m_swhb  = p_swhb;
        m_lu    = p_lu;
        if (grant_p) begin
            m_we = p_we;
        end else if (grant_a) begin
            m_we    = a_we;
            m_addr  = a_addr;
            m_wdata = a_wdata;
            m_lwhb  = a_lwhb;
            m_swhb  = a_swhb;
            m_lu    = a_lu;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (reset && contend) begin
            rr_ptr_d = grant_a ? PORT_P : PORT_A;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= PORT_P;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_a) begin
            starve_cnt_d = 4'd0;
        end else if (a_valid && starve_cnt_q != LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // Read ownership pipeline: the last stage lines up with m_rdata for the oldest outstanding read.
    always_comb begin
        own_v_d    = own_v_q;
        own_a_d    = own_a_q;
        for (int i = 1; i < RD_LAT; i++) begin
            own_v_d[i] = own_v_q[i-1];
            own_a_d[i] = own_a_q[i-1];
        end
        own_v_d[0] = read_issue;
        own_a_d[0] = grant_a;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            own_v_q <= '0;
            own_a_q <= '0;
        end else begin
            own_v_q <= own_v_d;
            own_a_q <= own_a_d;
        end
    end

    assign p_rvalid = own_v_q[RD_LAT-1] & ~own_a_q[RD_LAT-1];
    assign a_rvalid = own_v_q[RD_LAT-1] &  own_a_q[RD_LAT-1];
    assign p_rdata  = m_rdata;
    assign a_rdata  = m_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: one instance with RD_LAT=1, one with RD_LAT=3, sharing a dmem model.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_req1, a_valid1, p_req3, a_valid3;
    logic        p_we, a_we, p_lu, a_lu;
    logic [31:0] p_addr, p_wdata, a_addr, a_wdata;
    logic [1:0]  p_lwhb, p_swhb, a_lwhb, a_swhb;

    logic        p_stall1, p_rvalid1, a_ready1, a_rvalid1, m_en1, m_we1, m_lu1;
    logic [31:0] p_rdata1, a_rdata1, m_addr1, m_wdata1, m_rdata1;
    logic [1:0]  m_lwhb1, m_swhb1;

    logic        p_stall3, p_rvalid3, a_ready3, a_rvalid3, m_en3, m_we3, m_lu3;
    logic [31:0] p_rdata3, a_rdata3, m_addr3, m_wdata3, m_rdata3;
    logic [1:0]  m_lwhb3, m_swhb3;

    int checks = 0;
    int errors = 0;
    logic exp_stall;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.RD_LAT(1), .STARVE_LIM(4)) dut1 (
        .clk(clk), .reset(reset),
        .p_req(p_req1), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_lwhb(p_lwhb), .p_swhb(p_swhb), .p_lu(p_lu),
        .p_stall(p_stall1), .p_rvalid(p_rvalid1), .p_rdata(p_rdata1),
        .a_valid(a_valid1), .a_ready(a_ready1), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_lwhb(a_lwhb), .a_swhb(a_swhb), .a_lu(a_lu),
        .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
        .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_lwhb(m_lwhb1), .m_swhb(m_swhb1), .m_lu(m_lu1), .m_rdata(m_rdata1)
    );

    dmem_port_arbiter #(.RD_LAT(3), .STARVE_LIM(4)) dut3 (
        .clk(clk), .reset(reset),
        .p_req(p_req3), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_lwhb(p_lwhb), .p_swhb(p_swhb), .p_lu(p_lu),
        .p_stall(p_stall3), .p_rvalid(p_rvalid3), .p_rdata(p_rdata3),
        .a_valid(a_valid3), .a_ready(a_ready3), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_lwhb(a_lwhb), .a_swhb(a_swhb), .a_lu(a_lu),
        .a_rvalid(a_rvalid3), .a_rdata(a_rdata3),
        .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3),
        .m_lwhb(m_lwhb3), .m_swhb(m_swhb3), .m_lu(m_lu3), .m_rdata(m_rdata3)
    );

    // dmem model: word i holds 0xA0000000+i unless overwritten by the single store under test.
    logic        wr_has = 1'b0;
    logic [7:0]  wr_idx = 8'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] pipe1;
    logic [31:0] pipe3_0, pipe3_1, pipe3_2;

    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        if (wr_has && wr_idx == addr[9:2]) return wr_data;
        return 32'hA000_0000 + {24'd0, addr[9:2]};
    endfunction

    always @(posedge clk) begin
        if (m_en1 && m_we1) begin
            wr_has  <= 1'b1;
            wr_idx  <= m_addr1[9:2];
            wr_data <= m_wdata1;
        end
        pipe1   <= mem_rd(m_addr1);
        pipe3_0 <= mem_rd(m_addr3);
        pipe3_1 <= pipe3_0;
        pipe3_2 <= pipe3_1;
    end

    assign m_rdata1 = pipe1;
    assign m_rdata3 = pipe3_2;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic preq, input logic pwe, input logic [31:0] paddr,
                                 input logic avalid, input logic awe, input logic [31:0] aaddr,
                                 input logic [31:0] awdata);
        @(negedge clk);
        p_req1   = preq;
        p_we     = pwe;
        p_addr   = paddr;
        a_valid1 = avalid;
        a_we     = awe;
        a_addr   = aaddr;
        a_wdata  = awdata;
        #1;
    endtask

    task automatic drive3(input logic preq, input logic [31:0] paddr,
                          input logic avalid, input logic [31:0] aaddr);
        @(negedge clk);
        p_req3   = preq;
        p_addr   = paddr;
        a_valid3 = avalid;
        a_addr   = aaddr;
        p_we     = 1'b0;
        a_we     = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        p_req1 = 1'b1; a_valid1 = 1'b1; p_req3 = 1'b0; a_valid3 = 1'b0;
        p_we = 1'b0; a_we = 1'b0; p_lu = 1'b0; a_lu = 1'b0;
        p_addr = 32'd0; p_wdata = 32'd0; a_addr = 32'd0; a_wdata = 32'd0;
        p_lwhb = 2'b10; p_swhb = 2'b00; a_lwhb = 2'b00; a_swhb = 2'b00;

        // Reset held with both ports requesting: everything gated.
        @(negedge clk); #1;
        checkOutput("rst_m_en", {31'd0, m_en1}, 32'd0);
        checkOutput("rst_p_stall", {31'd0, p_stall1}, 32'd0);
        checkOutput("rst_a_ready", {31'd0, a_ready1}, 32'd0);
        checkOutput("rst_p_rvalid", {31'd0, p_rvalid1}, 32'd0);
        checkOutput("rst_m_we", {31'd0, m_we1}, 32'd0);
        p_req1 = 1'b0; a_valid1 = 1'b0;
        reset = 1'b1;

        // P-only read of 0x100.
        applyStimulus(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t1_m_en", {31'd0, m_en1}, 32'd1);
        checkOutput("t1_p_stall", {31'd0, p_stall1}, 32'd0);
        checkOutput("t1_m_addr", m_addr1, 32'h100);
        checkOutput("t1_m_lwhb", {30'd0, m_lwhb1}, 32'd2);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t1_p_rvalid", {31'd0, p_rvalid1}, 32'd1);
        checkOutput("t1_p_rdata", p_rdata1, 32'hA000_0040);
        checkOutput("t1_a_rvalid", {31'd0, a_rvalid1}, 32'd0);
        checkOutput("t1_idle_m_we", {31'd0, m_we1}, 32'd0);

        // A-only store then read back.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        checkOutput("t2_a_ready_w", {31'd0, a_ready1}, 32'd1);
        checkOutput("t2_m_we", {31'd0, m_we1}, 32'd1);
        checkOutput("t2_m_wdata", m_wdata1, 32'hDEAD_BEEF);
        checkOutput("t2_m_addr", m_addr1, 32'h40);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        checkOutput("t2_a_ready_r", {31'd0, a_ready1}, 32'd1);
        checkOutput("t2_m_we_r", {31'd0, m_we1}, 32'd0);
        checkOutput("t2_wr_no_rvalid", {31'd0, a_rvalid1}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t2_a_rvalid", {31'd0, a_rvalid1}, 32'd1);
        checkOutput("t2_a_rdata", a_rdata1, 32'hDEAD_BEEF);
        checkOutput("t2_p_rvalid", {31'd0, p_rvalid1}, 32'd0);

        // Continuous contention for 7 cycles.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
`ifdef DMEM_ARB_RR_EN
            exp_stall = (i % 2 == 1);
`else
            exp_stall = (i == 4);
`endif
            checkOutput($sformatf("t3_p_stall_%0d", i), {31'd0, p_stall1}, {31'd0, exp_stall});
            checkOutput($sformatf("t3_a_ready_%0d", i), {31'd0, a_ready1}, {31'd0, exp_stall});
        end

        // Reset pulse with a read in flight; then contention must restart from reset state.
        applyStimulus(1'b1, 1'b0, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t5_m_en_pre", {31'd0, m_en1}, 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("t5_m_en_rst", {31'd0, m_en1}, 32'd0);
        checkOutput("t5_p_stall_rst", {31'd0, p_stall1}, 32'd0);
        checkOutput("t5_p_rvalid_rst", {31'd0, p_rvalid1}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t5_p_rvalid_a", {31'd0, p_rvalid1}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            checkOutput($sformatf("t5_p_rvalid_post_%0d", i), {31'd0, p_rvalid1}, 32'd0);
            checkOutput($sformatf("t5_a_rvalid_post_%0d", i), {31'd0, a_rvalid1}, 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
`ifdef DMEM_ARB_RR_EN
            exp_stall = (i % 2 == 1);
`else
            exp_stall = (i == 4);
`endif
            checkOutput($sformatf("t5_p_stall_%0d", i), {31'd0, p_stall1}, {31'd0, exp_stall});
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // RD_LAT=3 instance: reads P,A,P back to back.
        drive3(1'b1, 32'h10, 1'b0, 32'h0);
        checkOutput("t4_m_en_c0", {31'd0, m_en3}, 32'd1);
        checkOutput("t4_p_stall_c0", {31'd0, p_stall3}, 32'd0);
        drive3(1'b0, 32'h0, 1'b1, 32'h20);
        checkOutput("t4_a_ready_c1", {31'd0, a_ready3}, 32'd1);
        checkOutput("t4_p_rvalid_c1", {31'd0, p_rvalid3}, 32'd0);
        drive3(1'b1, 32'h30, 1'b0, 32'h0);
        checkOutput("t4_m_addr_c2", m_addr3, 32'h30);
        checkOutput("t4_p_rvalid_c2", {31'd0, p_rvalid3}, 32'd0);
        drive3(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("t4_p_rvalid_c3", {31'd0, p_rvalid3}, 32'd1);
        checkOutput("t4_p_rdata_c3", p_rdata3, 32'hA000_0004);
        checkOutput("t4_a_rvalid_c3", {31'd0, a_rvalid3}, 32'd0);
        drive3(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("t4_a_rvalid_c4", {31'd0, a_rvalid3}, 32'd1);
        checkOutput("t4_a_rdata_c4", a_rdata3, 32'hA000_0008);
        checkOutput("t4_p_rvalid_c4", {31'd0, p_rvalid3}, 32'd0);
        drive3(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("t4_p_rvalid_c5", {31'd0, p_rvalid3}, 32'd1);
        checkOutput("t4_p_rdata_c5", p_rdata3, 32'hA000_000C);
        drive3(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("t4_p_rvalid_c6", {31'd0, p_rvalid3}, 32'd0);
        checkOutput("t4_a_rvalid_c6", {31'd0, a_rvalid3}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
